// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : riscv_pkg                                              |
// | Description : Shared RISC-V core types: base opcodes and the         |
// |               instruction-memory loader state encoding.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package riscv_pkg;

  // RV32I major opcodes (instruction bits [6:0])
  typedef enum logic [6:0] {
    OPC_LOAD   = 7'h03,
    OPC_OP_IMM = 7'h13,
    OPC_AUIPC  = 7'h17,
    OPC_STORE  = 7'h23,
    OPC_OP     = 7'h33,
    OPC_LUI    = 7'h37,
    OPC_BRANCH = 7'h63,
    OPC_JALR   = 7'h67,
    OPC_JAL    = 7'h6F,
    OPC_SYSTEM = 7'h73
  } opcode_e;

  // Program-loader sequencing states
  typedef enum logic [2:0] {
    LS_HDR   = 3'd0,
    LS_DATA  = 3'd1,
    LS_CSUM  = 3'd2,
    LS_DONE  = 3'd3,
    LS_ERROR = 3'd4
  } loader_state_e;

  // Bytes per instruction word; also the write-address stride
  localparam int unsigned C_WORD_BYTES = 4;

  // The loader takes stream bytes only while it is still parsing a stream
  function automatic logic state_accepts_bytes(input loader_state_e s);
    return (s == LS_HDR) || (s == LS_DATA) || (s == LS_CSUM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_byte_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : byte_assembler                                         |
// | Description : Collects four stream bytes into a little-endian 32-bit |
// |               word; flags the byte that completes the word.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module byte_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_complete
);

  // Only the first three bytes need storage; the fourth is combined on the fly
  logic [23:0] shreg_q, shreg_d;
  logic [1:0]  cnt_q, cnt_d;

  // Next-state: newest byte enters at the top so the oldest ends in [7:0]
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (shift_en) begin
      shreg_d = {byte_in, shreg_q[23:8]};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  // Assembly register and byte counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign word_out      = {byte_in, shreg_q};
  assign word_complete = shift_en && (cnt_q == 2'd3);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : imem_loader                                            |
// | Description : Parses a byte stream (count, words, XOR checksum) into |
// |               instruction-memory writes and holds the core in reset  |
// |               until a good image has been loaded.                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module imem_loader
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  loader_state_e state_q, state_d;
  logic          hdr_cnt_q, hdr_cnt_d;
  logic [7:0]    n_lo_q, n_lo_d;
  logic [15:0]   n_words_q, n_words_d;
  logic [15:0]   word_cnt_q, word_cnt_d;
  logic [7:0]    xor_q, xor_d;
  logic [31:0]   addr_q, addr_d;

  logic          byte_ready_q, byte_ready_d;
  logic          imem_we_q, imem_we_d;
  logic [31:0]   imem_waddr_q, imem_waddr_d;
  logic [31:0]   imem_wdata_q, imem_wdata_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic          load_done_q, load_done_d;
  logic          load_error_q, load_error_d;

  logic          w_accept;
  logic          w_restart;
  logic [15:0]   w_hdr_n;
  logic [15:0]   w_word_cnt_inc;
  logic [31:0]   w_word;
  logic          w_word_complete;

  assign w_accept       = byte_valid && byte_ready_q;
  assign w_restart      = start && ((state_q == LS_DONE) || (state_q == LS_ERROR));
  assign w_hdr_n        = {byte_data, n_lo_q};
  assign w_word_cnt_inc = word_cnt_q + 16'd1;

  byte_assembler u_byte_assembler (
    .clk           (clk),
    .reset         (reset),
    .clear         (w_restart),
    .shift_en      (w_accept && (state_q == LS_DATA)),
    .byte_in       (byte_data),
    .word_out      (w_word),
    .word_complete (w_word_complete)
  );

  // Stream parser: header decode, word writes, checksum verdict, restart
  always_comb begin
    state_d      = state_q;
    hdr_cnt_d    = hdr_cnt_q;
    n_lo_d       = n_lo_q;
    n_words_d    = n_words_q;
    word_cnt_d   = word_cnt_q;
    xor_d        = xor_q;
    addr_d       = addr_q;
    imem_we_d    = 1'b0;
    imem_waddr_d = imem_waddr_q;
    imem_wdata_d = imem_wdata_q;

    case (state_q)
      LS_HDR: begin
        if (w_accept) begin
          if (!hdr_cnt_q) begin
            n_lo_d    = byte_data;
            hdr_cnt_d = 1'b1;
          end else begin
            hdr_cnt_d = 1'b0;
            n_words_d = w_hdr_n;
            // 17-bit compare so a full 16-bit count never wraps past the limit
            if ({1'b0, w_hdr_n} > 17'(DEPTH_WORDS)) begin
              state_d = LS_ERROR;
            end else if (w_hdr_n == 16'd0) begin
              state_d = LS_CSUM;
            end else begin
              state_d = LS_DATA;
            end
          end
        end
      end

      LS_DATA: begin
        if (w_accept) begin
          xor_d = xor_q ^ byte_data;
          if (w_word_complete) begin
            imem_we_d    = 1'b1;
            imem_wdata_d = w_word;
            imem_waddr_d = addr_q;
            addr_d       = addr_q + 32'(C_WORD_BYTES);
            word_cnt_d   = w_word_cnt_inc;
            // Leave DATA on the same edge that raises the final write strobe
            if (w_word_cnt_inc == n_words_q) begin
              state_d = LS_CSUM;
            end
          end
        end
      end

      LS_CSUM: begin
        if (w_accept) begin
          state_d = (byte_data == xor_q) ? LS_DONE : LS_ERROR;
        end
      end

      LS_DONE, LS_ERROR: begin
        // Memory contents are left alone; only the parse context is reset
        if (start) begin
          state_d      = LS_HDR;
          hdr_cnt_d    = 1'b0;
          n_lo_d       = '0;
          n_words_d    = '0;
          word_cnt_d   = '0;
          xor_d        = '0;
          addr_d       = BASE_ADDR;
          imem_waddr_d = BASE_ADDR;
        end
      end

      default: begin
        state_d = LS_HDR;
      end
    endcase
  end

  // Status outputs are decoded from the next state so they register with it
  always_comb begin
    byte_ready_d = state_accepts_bytes(state_d);
    cpu_hold_d   = (state_d != LS_DONE);
    load_done_d  = (state_d == LS_DONE);
    load_error_d = (state_d == LS_ERROR);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= LS_HDR;
      hdr_cnt_q    <= 1'b0;
      n_lo_q       <= '0;
      n_words_q    <= '0;
      word_cnt_q   <= '0;
      xor_q        <= '0;
      addr_q       <= BASE_ADDR;
      byte_ready_q <= 1'b1;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= BASE_ADDR;
      imem_wdata_q <= '0;
      cpu_hold_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_cnt_q    <= hdr_cnt_d;
      n_lo_q       <= n_lo_d;
      n_words_q    <= n_words_d;
      word_cnt_q   <= word_cnt_d;
      xor_q        <= xor_d;
      addr_q       <= addr_d;
      byte_ready_q <= byte_ready_d;
      imem_we_q    <= imem_we_d;
      imem_waddr_q <= imem_waddr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_waddr = imem_waddr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_imem_loader                                         |
// | Description : Directed and randomized program streams for            |
// |               imem_loader, checked against a stream-level model.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_imem_loader;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  logic        exp_done;
  logic        exp_err;
  int          exp_consumed;

  imem_loader #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  // Capture every cycle the write strobe is high
  always @(negedge clk) begin
    if (imem_we) got_q.push_back({imem_waddr, imem_wdata});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: interpret the stream by its format rules
  task automatic model(input bq_t s);
    int          n;
    logic [7:0]  x;
    logic [31:0] w;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    n = int'({s[1], s[0]});
    if (n > int'(DEPTH)) begin
      exp_err      = 1'b1;
      exp_consumed = 2;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = {s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]};
      exp_q.push_back({BASE + 32'(4*i), w});
      for (int k = 0; k < 4; k++) x = x ^ s[2+4*i+k];
    end
    exp_consumed = 2 + 4*n + 1;
    if (s[2+4*n] == x) exp_done = 1'b1;
    else               exp_err  = 1'b1;
  endtask

  // Entered and left just after a falling edge
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (!byte_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("byte_accept_timeout", 64'(t), 64'(0));
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
  endtask

  task automatic run_stream(input string name, input bq_t s, input int maxgap);
    got_q.delete();
    model(s);
    for (int i = 0; i < exp_consumed; i++) send_byte(s[i], int'($urandom_range(0, maxgap)));
    repeat (3) @(negedge clk);
    chk($sformatf("%s nwrites", name), 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s write%0d", name, i), got_q[i], exp_q[i]);
    chk($sformatf("%s load_done", name),  64'(load_done),  64'(exp_done));
    chk($sformatf("%s load_error", name), 64'(load_error), 64'(exp_err));
    chk($sformatf("%s cpu_hold", name),   64'(cpu_hold),   64'(!exp_done));
    chk($sformatf("%s byte_ready", name), 64'(byte_ready), 64'(0));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart byte_ready", 64'(byte_ready), 64'(1));
    chk("restart flags", 64'({load_done, load_error, cpu_hold}), 64'(3'b001));
  endtask

  initial begin
    bq_t s;
    bq_t prog;
    int  n;
    logic [7:0] x;
    logic [7:0] b;

    reset      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    #2 reset = 1'b1;
    #1;
    chk("reset outputs",
        64'({byte_ready, imem_we, cpu_hold, load_done, load_error}), 64'(5'b10100));
    chk("reset waddr", 64'(imem_waddr), 64'(BASE));
    chk("reset wdata", 64'(imem_wdata), 64'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Two-word program; XOR of the eight payload bytes is 0xB0
    prog = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
    run_stream("two_words", prog, 0);
    chk("two_words literal w0", got_q[0], {32'h0, 32'h0010_0513});
    chk("two_words literal w1", got_q[1], {32'h4, 32'h0020_0593});

    // Same payload, wrong checksum
    pulse_start();
    s = prog;
    s[10] = 8'h91;
    run_stream("bad_csum", s, 0);

    // Empty program
    pulse_start();
    s = '{8'h00, 8'h00, 8'h00};
    run_stream("empty", s, 0);

    // Count above depth: error after the header, extra bytes dropped
    pulse_start();
    s = '{8'h01, 8'h01};
    run_stream("too_long", s, 0);
    byte_valid = 1'b1;
    byte_data  = 8'h13;
    repeat (4) @(negedge clk);
    byte_valid = 1'b0;
    chk("too_long dropped nwrites", 64'(got_q.size()), 64'(0));
    chk("too_long still error", 64'({load_error, byte_ready}), 64'(2'b10));

    // Reset in the middle of a word
    pulse_start();
    got_q.delete();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    reset = 1'b1;
    #1;
    chk("midword reset we/ready", 64'({imem_we, byte_ready, cpu_hold}), 64'(3'b011));
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("midword reset nwrites", 64'(got_q.size()), 64'(0));
    run_stream("after_reset", prog, 0);

    // Gapped reloads must reproduce the same writes
    for (int r = 0; r < 2; r++) begin
      pulse_start();
      run_stream($sformatf("gapped_reload%0d", r), prog, 3);
    end

    // Randomized programs
    for (int r = 0; r < 20; r++) begin
      pulse_start();
      n = int'($urandom_range(0, 6));
      s.delete();
      s.push_back(8'(n));
      s.push_back(8'(n >> 8));
      x = 8'h00;
      for (int i = 0; i < 4*n; i++) begin
        b = 8'($urandom);
        x = x ^ b;
        s.push_back(b);
      end
      if ($urandom_range(0, 1) == 1) s.push_back(x);
      else                           s.push_back(x ^ 8'($urandom_range(1, 255)));
      run_stream($sformatf("rand%0d", r), s, 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
